// File: rtl/keypad_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl_if
//
// Purpose : bundles the keypad-facing and display-facing signals of the keypad
//           scan controller so the controller and its environment connect
//           through one port.
//
// Signals :
//   col        raw column sense, active-high, asynchronous to the clock
//   row        one-hot active-high row drive
//   key_valid  one-cycle pulse when a debounced press is accepted
//   key_held   high from acceptance until the debounced release completes
//   N1         newest key code {row_idx, col_idx}
//   N2         previous key code
//
// Modports:
//   master     the scan controller (reads col, drives everything else)
//   slave      the keypad / display side (drives col, reads everything else)
// -----------------------------------------------------------------------------
interface keypad_scan_ctrl_if;
   logic [3:0] col;
   logic [3:0] row;
   logic       key_valid;
   logic       key_held;
   logic [3:0] N1;
   logic [3:0] N2;

   modport master (
      input  col,
      output row,
      output key_valid,
      output key_held,
      output N1,
      output N2
   );

   modport slave (
      output col,
      input  row,
      input  key_valid,
      input  key_held,
      input  N1,
      input  N2
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Purpose : scans a 4x4 keypad one row at a time, synchronises the column
//           sense lines, debounces press and release, and keeps a two-deep
//           history of accepted key codes for the hex display.
//
// Ports   :
//   clk    system clock
//   reset  asynchronous, active-low reset
//   kp     keypad_scan_ctrl_if.master
//            kp.col        raw column sense (async, active-high)
//            kp.row        one-hot row drive
//            kp.key_valid  one-cycle pulse on debounced press acceptance
//            kp.key_held   high while the accepted key is still down
//            kp.N1 / kp.N2 newest / previous key code {row_idx, col_idx}
//
// Parameters:
//   SCAN_DIV    cycles each row is driven while scanning (>= 4)
//   DB_CYCLES   consecutive stable cycles to accept a press or release (>= 2)
//   RESET_CODE  reset value of both digit registers (13 = key '0')
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV   = 4,
   parameter int unsigned DB_CYCLES  = 8,
   parameter logic [3:0]  RESET_CODE = 4'd13
) (
   input logic                clk,
   input logic                reset,
   keypad_scan_ctrl_if.master kp
);

   localparam int unsigned DWELL_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   // Column priority: the highest asserted column wins.
   function automatic logic [1:0] top_col(input logic [3:0] c);
      if (c[3]) begin
         return 2'd3;
      end else if (c[2]) begin
         return 2'd2;
      end else if (c[1]) begin
         return 2'd1;
      end else begin
         return 2'd0;
      end
   endfunction

   // Synchroniser
   logic [3:0] col_s1_q;
   logic [3:0] cs_q;

   // Controller state
   state_t             state_q,     state_d;
   logic [3:0]         row_q,       row_d;
   logic [1:0]         row_idx_q,   row_idx_d;
   logic [DWELL_W-1:0] dwell_q,     dwell_d;
   logic [DB_W-1:0]    db_q,        db_d;
   logic [1:0]         cap_row_q,   cap_row_d;
   logic [1:0]         cap_col_q,   cap_col_d;
   logic               key_valid_q, key_valid_d;
   logic               key_held_q,  key_held_d;
   logic [3:0]         n1_q,        n1_d;
   logic [3:0]         n2_q,        n2_d;

   // Helpers shared by every path that resumes scanning.
   logic [3:0] row_rot;
   logic [1:0] row_idx_inc;
   logic       col_hit;

   assign row_rot     = {row_q[2:0], row_q[3]};
   assign row_idx_inc = row_idx_q + 2'd1;
   // Only the captured column matters once a key has been latched; this is
   // what suppresses rollover while a key is held.
   assign col_hit     = cs_q[cap_col_q];

   // ---- stage: column synchroniser (two flops, all decisions use cs_q) ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_s1_q <= 4'b0000;
         cs_q     <= 4'b0000;
      end else begin
         col_s1_q <= kp.col;
         cs_q     <= col_s1_q;
      end
   end

   // ---- stage: controller state register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         row_q       <= 4'b0001;
         row_idx_q   <= 2'd0;
         dwell_q     <= '0;
         db_q        <= '0;
         cap_row_q   <= 2'd0;
         cap_col_q   <= 2'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         n1_q        <= RESET_CODE;
         n2_q        <= RESET_CODE;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         row_idx_q   <= row_idx_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         cap_row_q   <= cap_row_d;
         cap_col_q   <= cap_col_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         n1_q        <= n1_d;
         n2_q        <= n2_d;
      end
   end

   // ---- stage: next-state logic ----
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      row_idx_d   = row_idx_q;
      dwell_d     = dwell_q;
      db_d        = db_q;
      cap_row_d   = cap_row_q;
      cap_col_d   = cap_col_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      n1_d        = n1_q;
      n2_d        = n2_q;

      unique case (state_q)
         SCAN: begin
            // Columns are only sampled on the last dwell cycle so the row
            // drive has had time to settle through the synchroniser.
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (cs_q == 4'b0000) begin
                  row_d     = row_rot;
                  row_idx_d = row_idx_inc;
               end else begin
                  cap_row_d = row_idx_q;
                  cap_col_d = top_col(cs_q);
                  db_d      = '0;
                  state_d   = PRESS_DB;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end

         PRESS_DB: begin
            if (col_hit) begin
               if (db_q == DB_LAST) begin
                  n2_d        = n1_q;
                  n1_d        = {cap_row_q, cap_col_q};
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = HELD;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               // Bounce: drop the candidate and move on to the next row.
               row_d     = row_rot;
               row_idx_d = row_idx_inc;
               dwell_d   = '0;
               state_d   = SCAN;
            end
         end

         HELD: begin
            if (!col_hit) begin
               db_d    = '0;
               state_d = REL_DB;
            end
         end

         REL_DB: begin
            if (!col_hit) begin
               if (db_q == DB_LAST) begin
                  key_held_d = 1'b0;
                  row_d      = row_rot;
                  row_idx_d  = row_idx_inc;
                  dwell_d    = '0;
                  state_d    = SCAN;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               state_d = HELD;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase
   end

   assign kp.row       = row_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;
   assign kp.N1        = n1_q;
   assign kp.N2        = n2_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

   localparam int         SCAN_DIV  = 4;
   localparam int         DB_CYCLES = 8;
   localparam logic [3:0] RC        = 4'd13;
   localparam int         LAT_MAX   = SCAN_DIV * 4 + 2 + DB_CYCLES + 1;

   logic clk = 1'b0;
   logic reset;

   keypad_scan_ctrl_if kif ();

   keypad_scan_ctrl #(
      .SCAN_DIV  (SCAN_DIV),
      .DB_CYCLES (DB_CYCLES),
      .RESET_CODE(RC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .kp   (kif.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int kv_seen  = 0;

   // Reference model: scan position, run-length of stable samples, history.
   int         m_mode;   // 0 scanning, 1 confirming press, 2 holding, 3 confirming release
   int         m_ridx;
   int         m_tick;
   int         m_run;
   logic [1:0] m_crow, m_ccol;
   logic [3:0] m_s1, m_cs;
   logic       m_kv, m_kh;
   logic [3:0] m_n1, m_n2;

   function automatic logic [1:0] top_bit(input logic [3:0] c);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (c[i]) r = 2'(i);
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ridx = 0; m_tick = 0; m_run = 0;
      m_crow = 2'd0; m_ccol = 2'd0;
      m_s1 = 4'b0; m_cs = 4'b0;
      m_kv = 1'b0; m_kh = 1'b0;
      m_n1 = RC; m_n2 = RC;
   endtask

   task automatic model_tick(input logic [3:0] c);
      logic [3:0] seen;
      seen = m_cs;          // value the controller acts on this cycle
      m_cs = m_s1;
      m_s1 = c;
      m_kv = 1'b0;
      case (m_mode)
         0: begin
            if (m_tick == SCAN_DIV - 1) begin
               m_tick = 0;
               if (seen == 4'b0) begin
                  m_ridx = (m_ridx + 1) % 4;
               end else begin
                  m_crow = 2'(m_ridx);
                  m_ccol = top_bit(seen);
                  m_run  = 0;
                  m_mode = 1;
               end
            end else begin
               m_tick = m_tick + 1;
            end
         end
         1: begin
            if (seen[m_ccol]) begin
               m_run = m_run + 1;
               if (m_run == DB_CYCLES) begin
                  m_n2 = m_n1; m_n1 = {m_crow, m_ccol};
                  m_kv = 1'b1; m_kh = 1'b1; m_mode = 2;
               end
            end else begin
               m_mode = 0; m_ridx = (m_ridx + 1) % 4; m_tick = 0;
            end
         end
         2: begin
            if (!seen[m_ccol]) begin
               m_run = 0; m_mode = 3;
            end
         end
         default: begin
            if (!seen[m_ccol]) begin
               m_run = m_run + 1;
               if (m_run == DB_CYCLES) begin
                  m_kh = 1'b0; m_mode = 0; m_ridx = (m_crow + 1) % 4; m_tick = 0;
               end
            end else begin
               m_mode = 2;
            end
         end
      endcase
   endtask

   // One clock cycle: advance the model, then compare every output to it.
   task automatic step();
      logic [3:0] er;
      @(posedge clk);
      if (!reset) model_reset();
      else model_tick(kif.col);
      #1;
      cyc++;
      if (kif.key_valid === 1'b1) kv_seen++;
      er = 4'b0001 << m_ridx;
      n_checks++;
      if (kif.row !== er) $display("FAIL cyc_row cyc=%0d got=%b exp=%b", cyc, kif.row, er);
      else n_pass++;
      n_checks++;
      if (kif.key_valid !== m_kv) $display("FAIL cyc_key_valid cyc=%0d got=%b exp=%b", cyc, kif.key_valid, m_kv);
      else n_pass++;
      n_checks++;
      if (kif.key_held !== m_kh) $display("FAIL cyc_key_held cyc=%0d got=%b exp=%b", cyc, kif.key_held, m_kh);
      else n_pass++;
      n_checks++;
      if (kif.N1 !== m_n1) $display("FAIL cyc_N1 cyc=%0d got=%b exp=%b", cyc, kif.N1, m_n1);
      else n_pass++;
      n_checks++;
      if (kif.N2 !== m_n2) $display("FAIL cyc_N2 cyc=%0d got=%b exp=%b", cyc, kif.N2, m_n2);
      else n_pass++;
   endtask

   // Step until the row drive switches to r (bounded).
   task automatic wait_row(input logic [3:0] r, output bit ok);
      logic [3:0] prev;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         prev = kif.row;
         step();
         if (kif.row == r && prev != r) ok = 1'b1;
      end
   endtask

   task automatic wait_kv(output bit ok, output int lat);
      int k0;
      k0 = kv_seen; ok = 1'b0; lat = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         lat++;
         if (kv_seen != k0) ok = 1'b1;
      end
   endtask

   task automatic wait_release(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         if (kif.key_held === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_rows [4];
      exp_rows = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset   = 1'b0;
      kif.col = 4'b0;
      model_reset();
      repeat (3) step();
      n_checks++;
      if (kif.row !== 4'b0001) $display("FAIL reset_row got=%b exp=0001", kif.row); else n_pass++;
      n_checks++;
      if (kif.N1 !== RC || kif.N2 !== RC) $display("FAIL reset_digits got=%0d,%0d exp=13,13", kif.N1, kif.N2); else n_pass++;
      n_checks++;
      if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0)
         $display("FAIL reset_flags got=%b%b exp=00", kif.key_valid, kif.key_held);
      else n_pass++;
      reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k % 4 == 0) begin
            n_checks++;
            if (kif.row !== exp_rows[k/4 - 1]) $display("FAIL scan_seq k=%0d got=%b exp=%b", k, kif.row, exp_rows[k/4 - 1]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_clean_press();
      bit ok;
      int k0, lat, first;
      wait_row(4'b0010, ok);
      n_checks++;
      if (!ok) $display("FAIL press_wait_row got=timeout exp=row0010"); else n_pass++;
      kif.col = 4'b0100;
      k0 = kv_seen; first = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (first == 0 && kv_seen != k0) first = i;
      end
      lat = first;
      n_checks++;
      if (kv_seen - k0 != 1) $display("FAIL press_pulses got=%0d exp=1", kv_seen - k0); else n_pass++;
      n_checks++;
      if (lat < 1 || lat > LAT_MAX) $display("FAIL press_latency got=%0d exp=1..%0d", lat, LAT_MAX); else n_pass++;
      n_checks++;
      if (kif.N1 !== 4'b0110 || kif.N2 !== RC) $display("FAIL press_digits got=%b,%b exp=0110,1101", kif.N1, kif.N2); else n_pass++;
      n_checks++;
      if (kif.key_held !== 1'b1 || kif.row !== 4'b0010)
         $display("FAIL press_hold got=held%b row%b exp=held1 row0010", kif.key_held, kif.row);
      else n_pass++;
   endtask

   task automatic test_release_bounce();
      bit ok;
      int k0;
      k0 = kv_seen;
      kif.col = 4'b0000; repeat (4) step();
      kif.col = 4'b0100; repeat (2) step();
      kif.col = 4'b0000;
      n_checks++;
      if (kif.key_held !== 1'b1) $display("FAIL rel_bounce_held got=%b exp=1", kif.key_held); else n_pass++;
      wait_release(ok);
      n_checks++;
      if (!ok) $display("FAIL rel_done got=timeout exp=key_held0"); else n_pass++;
      n_checks++;
      if (kif.row !== 4'b0100) $display("FAIL rel_resume_row got=%b exp=0100", kif.row); else n_pass++;
      n_checks++;
      if (kv_seen != k0) $display("FAIL rel_extra_pulse got=%0d exp=0", kv_seen - k0); else n_pass++;
   endtask

   task automatic test_bounce_reject();
      bit ok;
      int k0;
      logic pat [7];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      wait_row(4'b1000, ok);
      n_checks++;
      if (!ok) $display("FAIL bounce_wait_row got=timeout exp=row1000"); else n_pass++;
      k0 = kv_seen;
      for (int j = 0; j < 7; j++) begin
         kif.col = {3'b000, pat[j]};
         step();
         if (j == 5) begin
            n_checks++;
            if (kif.row !== 4'b0001) $display("FAIL bounce_resume_row got=%b exp=0001", kif.row); else n_pass++;
         end
      end
      kif.col = 4'b0000;
      repeat (12) step();
      n_checks++;
      if (kv_seen != k0) $display("FAIL bounce_pulse got=%0d exp=0", kv_seen - k0); else n_pass++;
      n_checks++;
      if (kif.N1 !== 4'b0110 || kif.N2 !== RC) $display("FAIL bounce_digits got=%b,%b exp=0110,1101", kif.N1, kif.N2); else n_pass++;
   endtask

   task automatic test_history_priority();
      bit ok;
      int lat;
      wait_row(4'b0001, ok);
      kif.col = 4'b1000;
      wait_kv(ok, lat);
      n_checks++;
      if (!ok) $display("FAIL hist_press1 got=timeout exp=key_valid"); else n_pass++;
      repeat (5) step();
      kif.col = 4'b0000;
      wait_release(ok);
      n_checks++;
      if (kif.N1 !== 4'b0011 || kif.N2 !== 4'b0110) $display("FAIL hist_first got=%b,%b exp=0011,0110", kif.N1, kif.N2); else n_pass++;
      wait_row(4'b1000, ok);
      kif.col = 4'b1010;
      wait_kv(ok, lat);
      n_checks++;
      if (!ok) $display("FAIL hist_press2 got=timeout exp=key_valid"); else n_pass++;
      n_checks++;
      if (kif.N1 !== 4'b1111 || kif.N2 !== 4'b0011) $display("FAIL hist_priority got=%b,%b exp=1111,0011", kif.N1, kif.N2); else n_pass++;
      kif.col = 4'b0000;
      wait_release(ok);
      n_checks++;
      if (!ok) $display("FAIL hist_release got=timeout exp=key_held0"); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k0;
      wait_row(4'b0100, ok);
      k0 = kv_seen;
      kif.col = 4'b0010;
      repeat (6) step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (kif.N1 !== RC || kif.N2 !== RC) $display("FAIL midrst_digits got=%b,%b exp=1101,1101", kif.N1, kif.N2); else n_pass++;
      n_checks++;
      if (kif.row !== 4'b0001 || kif.key_held !== 1'b0 || kif.key_valid !== 1'b0)
         $display("FAIL midrst_ctrl got=row%b kv%b kh%b exp=row0001 kv0 kh0", kif.row, kif.key_valid, kif.key_held);
      else n_pass++;
      n_checks++;
      if (dut.state_q !== 2'd0) $display("FAIL midrst_state got=%0d exp=0", dut.state_q); else n_pass++;
      model_reset();
      kif.col = 4'b0000;
      repeat (2) step();
      reset = 1'b1;
      repeat (30) step();
      n_checks++;
      if (kv_seen != k0) $display("FAIL midrst_pulse got=%0d exp=0", kv_seen - k0); else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] c;
      int len;
      for (int n = 0; n < 120; n++) begin
         c   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         len = $urandom_range(1, 24);
         kif.col = c;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 299) == 0) begin
               reset = 1'b0;
               step();
               reset = 1'b1;
            end else begin
               step();
            end
         end
      end
      kif.col = 4'b0000;
      repeat (40) step();
   endtask

   initial begin
      reset   = 1'b0;
      kif.col = 4'b0000;
      test_reset();
      test_clean_press();
      test_release_bounce();
      test_bounce_reject();
      test_history_priority();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 keypad. Drives one row at a time and synchronizes the column inputs.
- Runs a debounce FSM for press and release, and converts the first debounced press into a 4-bit key coordinate.
- Keeps a two-entry digit history (newest, previous) for the hex display path.
- Replaces the free-running row counter and bounce handling with a single clocked controller.

Parameters:
- SCAN_DIV, 4, clock cycles each row is driven during scanning; minimum 4, which covers the 2-FF sync latency plus settling.
- DB_CYCLES, 8, consecutive stable cycles needed to accept a press or a release; minimum 2.
- RESET_CODE, 4'd13, reset value of both digit outputs (13 is the keypad coordinate of key '0').

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- col  in  4  raw column sense, active-high, asynchronous to clk.
- row  out  4  one-hot active-high row drive.
- key_valid  out  1  one-cycle pulse when a debounced press is accepted.
- key_held  out  1  high from acceptance until the debounced release completes.
- N1  out  4  newest key code {row_idx[1:0], col_idx[1:0]}.
- N2  out  4  previous key code.

Behaviour:
- Reset is asynchronous on reset low:
  - state = SCAN, row = 4'b0001, row_idx = 0, dwell and debounce counters = 0.
  - sync FFs = 0, key_valid = 0, key_held = 0.
  - N1 = N2 = RESET_CODE.
  - Reset asserted mid-debounce or mid-hold aborts without updating the digits.
- Column sync: 2-FF synchronizer on col gives cs. All decisions use cs only.
- Column priority: col_idx = highest set bit of cs (3 > 2 > 1 > 0).
- FSM states: SCAN, PRESS_DB, HELD, REL_DB.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1.
  - At dwell == SCAN_DIV-1 with cs == 0: row rotates left (0001 -> 0010 -> 0100 -> 1000 -> 0001), row_idx increments mod 4, dwell = 0.
  - At dwell == SCAN_DIV-1 with cs != 0: capture cap_row = row_idx and cap_col = col_idx, row freezes, db counter = 0, go to PRESS_DB.
  - cs is ignored at any other dwell value.
- PRESS_DB:
  - Each cycle with cs[cap_col] == 1: db increments.
  - When db reaches DB_CYCLES-1 with cs[cap_col] still high:
    - N2 <= N1, N1 <= {cap_row, cap_col}.
    - key_valid = 1 for exactly that next cycle; key_held = 1.
    - Go to HELD.
  - If cs[cap_col] == 0 on any cycle: glitch rejected. Return to SCAN, advance to the next row, dwell = 0, no digit update.
- HELD:
  - Row stays frozen at cap_row. Other columns and rows are ignored, so no rollover: a second key pressed while holding is never reported.
  - cs[cap_col] == 0 -> db = 0, go to REL_DB.
- REL_DB:
  - Each cycle with cs[cap_col] == 0: db increments.
  - When db reaches DB_CYCLES-1: key_held = 0, go to SCAN, resume at the next row, dwell = 0.
  - cs[cap_col] == 1 on any cycle: return to HELD with no event.
- Latency: a clean press on the driven row gives key_valid at most SCAN_DIV*4 + 2 + DB_CYCLES + 1 cycles after col rises.
- Press at the exact dwell boundary: a press first seen at dwell == SCAN_DIV-1 is captured. A press first seen one cycle later is captured on a later pass over that row.
- Counter widths: each is sized as clog2 of its terminal count. No counter wraps except dwell in SCAN.

Test Plan:
(Parameters for all scenarios: SCAN_DIV=4, DB_CYCLES=8.)
1. Reset check: hold reset low for 3 cycles -> row=0001, N1=N2=13, key_valid=0, key_held=0. Release with col=0 -> row sequence 0001,0010,0100,1000,0001 changing every 4 cycles.
2. Clean press: assert col=4'b0100 whenever row=0010 and hold it for 40 cycles -> exactly one key_valid pulse; N1=4'b0110, N2=13; key_held=1; row frozen at 0010 while held.
3. Bounce rejection: on row 1000, col=4'b0001 goes high 3 cycles, low 1, high 3 -> no key_valid, N1 unchanged, scanning resumes at row 0001.
4. Release bounce: after the press in scenario 2, drop col for 4 cycles, raise for 2, then drop permanently -> key_held stays 1 until 8 consecutive low cycles; then key_held=0 and scanning resumes at row 0100; no extra key_valid.
5. History and priority: press row 0 col 3, release, then press row 3 with col=4'b1010 -> N1=4'b1111, N2=4'b0011; the col 3 bit wins the priority.
6. Reset mid-operation: assert reset low during PRESS_DB -> N1/N2 return to 13 immediately, state=SCAN, no key_valid ever emitted for that press.
